// File: rtl/hwpe_ctrl_regfile_access.sv
// Bridges a req/gnt configuration bus onto a register file and sequences a bulk clear.
// Optional macro HWPE_CTRL_REGFILE_FWD_EN: forward the last write into a following read instead of stalling.
`timescale 1ns/1ps

module hwpe_ctrl_regfile_access #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // cfg_req/cfg_gnt: a request is accepted in the cycle cfg_gnt is high; the master holds
    // cfg_add/cfg_wen/cfg_be/cfg_data stable until then. An accepted read is answered by
    // cfg_r_valid exactly one cycle later; an accepted write has no response.
    input  logic                  cfg_req,
    output logic                  cfg_gnt,
    input  logic [ADDR_WIDTH-1:0] cfg_add,
    input  logic                  cfg_wen,
    input  logic [NUM_BYTE-1:0]   cfg_be,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic [DATA_WIDTH-1:0] cfg_r_data,
    output logic                  cfg_r_valid,
    input  logic                  clear_req,
    output logic                  clear_done,
    output logic                  rf_clear,
    output logic                  rf_ReadEnable,
    output logic [ADDR_WIDTH-1:0] rf_ReadAddr,
    input  logic [DATA_WIDTH-1:0] rf_ReadData,
    output logic                  rf_WriteEnable,
    output logic [ADDR_WIDTH-1:0] rf_WriteAddr,
    output logic [DATA_WIDTH-1:0] rf_WriteData,
    output logic [NUM_BYTE-1:0]   rf_WriteBE
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        CLEAR      = 2'd1,
        CLEAR_WAIT = 2'd2
    } state_t;

    state_t                  state;
    logic                    last_wr_valid;
    logic [ADDR_WIDTH-1:0]   last_wr_addr;
    logic                    r_valid_q;
    logic                    hazard;
    logic                    gnt;
    logic                    rd_gnt;
    logic                    wr_gnt;

    // Every output is gated by rst so the port is quiet for the whole reset cycle.
    assign gnt    = ~rst & (state == RUN) & cfg_req & ~clear_req & ~hazard;
    assign rd_gnt = gnt & cfg_wen;
    assign wr_gnt = gnt & ~cfg_wen;

    assign cfg_gnt        = gnt;
    assign rf_ReadEnable  = rd_gnt;
    assign rf_ReadAddr    = rd_gnt ? cfg_add : '0;
    assign rf_WriteEnable = wr_gnt;
    assign rf_WriteAddr   = wr_gnt ? cfg_add : '0;
    assign rf_WriteData   = wr_gnt ? cfg_data : '0;
    assign rf_WriteBE     = wr_gnt ? cfg_be : '0;
    assign rf_clear       = ~rst & (state == CLEAR);
    assign clear_done     = ~rst & (state == CLEAR_WAIT);
    assign cfg_r_valid    = ~rst & r_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            last_wr_valid <= 1'b0;
            last_wr_addr  <= '0;
            r_valid_q     <= 1'b0;
        end else begin
            case (state)
                RUN:        if (clear_req) state <= CLEAR;
                CLEAR:      state <= CLEAR_WAIT;
                CLEAR_WAIT: state <= RUN;
                default:    state <= RUN;
            endcase
            last_wr_valid <= wr_gnt;
            if (wr_gnt) last_wr_addr <= cfg_add;
            r_valid_q <= rd_gnt;
        end
    end

`ifdef HWPE_CTRL_REGFILE_FWD_EN
    // The last write's data/strobes only matter when they can be forwarded.
    logic [DATA_WIDTH-1:0] last_wr_data;
    logic [NUM_BYTE-1:0]   last_wr_be;
    logic                  fwd_q;

    assign hazard = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_data <= '0;
            last_wr_be   <= '0;
            fwd_q        <= 1'b0;
        end else begin
            if (wr_gnt) begin
                last_wr_data <= cfg_data;
                last_wr_be   <= cfg_be;
            end
            fwd_q <= rd_gnt & last_wr_valid & (cfg_add == last_wr_addr);
        end
    end

    always_comb begin
        cfg_r_data = '0;
        if (cfg_r_valid) begin
            for (int i = 0; i < NUM_BYTE; i++) begin
                cfg_r_data[8*i +: 8] = (fwd_q & last_wr_be[i]) ? last_wr_data[8*i +: 8]
                                                               : rf_ReadData[8*i +: 8];
            end
        end
    end
`else
    // A read of the address written last cycle waits one bubble for the file to settle.
    assign hazard     = last_wr_valid & cfg_wen & (cfg_add == last_wr_addr);
    assign cfg_r_data = cfg_r_valid ? rf_ReadData : '0;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_regfile_access.sv
// Bench for hwpe_ctrl_regfile_access: behavioural register file, reference memory and read scoreboard.
`timescale 1ns/1ps

module tb_hwpe_ctrl_regfile_access;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_req, cfg_gnt, cfg_wen, cfg_r_valid;
    logic [AW-1:0] cfg_add;
    logic [NB-1:0] cfg_be;
    logic [DW-1:0] cfg_data, cfg_r_data;
    logic          clear_req, clear_done, rf_clear;
    logic          rf_ReadEnable, rf_WriteEnable;
    logic [AW-1:0] rf_ReadAddr, rf_WriteAddr;
    logic [DW-1:0] rf_ReadData, rf_WriteData;
    logic [NB-1:0] rf_WriteBE;

    int            total;
    int            bad;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem[32];
    logic [DW-1:0] rf_mem[32];
    logic          pend_rd;

    always #5 clk = ~clk;

    hwpe_ctrl_regfile_access #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) dut (
        .clk(clk), .rst(rst),
        .cfg_req(cfg_req), .cfg_gnt(cfg_gnt), .cfg_add(cfg_add), .cfg_wen(cfg_wen),
        .cfg_be(cfg_be), .cfg_data(cfg_data), .cfg_r_data(cfg_r_data), .cfg_r_valid(cfg_r_valid),
        .clear_req(clear_req), .clear_done(clear_done), .rf_clear(rf_clear),
        .rf_ReadEnable(rf_ReadEnable), .rf_ReadAddr(rf_ReadAddr), .rf_ReadData(rf_ReadData),
        .rf_WriteEnable(rf_WriteEnable), .rf_WriteAddr(rf_WriteAddr),
        .rf_WriteData(rf_WriteData), .rf_WriteBE(rf_WriteBE)
    );

    // External register file: byte-masked write, clear, one-cycle read latency.
    always @(posedge clk) begin
        if (rf_clear === 1'b1) begin
            for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        end else if (rf_WriteEnable === 1'b1) begin
            for (int b = 0; b < NB; b++)
                if (rf_WriteBE[b]) rf_mem[rf_WriteAddr][8*b +: 8] = rf_WriteData[8*b +: 8];
        end
        if (rf_ReadEnable === 1'b1) rf_ReadData <= rf_mem[rf_ReadAddr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic req, input logic wen, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [NB-1:0] be, input logic clr);
        cfg_req   = req;
        cfg_wen   = wen;
        cfg_add   = addr;
        cfg_data  = data;
        cfg_be    = be;
        clear_req = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, '0, '0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    endtask

    // Compares this cycle's response against the queue, then records this cycle's grant.
    task automatic scoreboard();
        logic          exp_v;
        logic [DW-1:0] e;
        exp_v = pend_rd & ~rst;
        total++;
        if (cfg_r_valid !== exp_v) begin
            bad++;
            $display("FAIL sb_r_valid got=%0b want=%0b t=%0t", cfg_r_valid, exp_v, $time);
        end
        if (pend_rd && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (exp_v) begin
                total++;
                if (cfg_r_data !== e) begin
                    bad++;
                    $display("FAIL sb_r_data got=%h want=%h t=%0t", cfg_r_data, e, $time);
                end
            end
        end
        if (!exp_v) begin
            total++;
            if (cfg_r_data !== '0) begin
                bad++;
                $display("FAIL sb_r_data_idle got=%h want=0 t=%0t", cfg_r_data, $time);
            end
        end
        pend_rd = 1'b0;
        if (!rst && cfg_gnt === 1'b1) begin
            if (cfg_wen) begin
                exp_q.push_back(ref_mem[cfg_add]);
                pend_rd = 1'b1;
            end else begin
                for (int b = 0; b < NB; b++)
                    if (cfg_be[b]) ref_mem[cfg_add][8*b +: 8] = cfg_data[8*b +: 8];
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        scoreboard();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd3, '0, '0, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0b want=0", cfg_gnt); end
        total++; if (rf_ReadEnable !== 1'b0 || rf_ReadAddr !== '0) begin bad++; $display("FAIL rst_rd got=%0b/%0d want=0/0", rf_ReadEnable, rf_ReadAddr); end
        total++; if (rf_clear !== 1'b0 || clear_done !== 1'b0) begin bad++; $display("FAIL rst_clear got=%0b%0b want=00", rf_clear, clear_done); end
        tick();
        drive(1'b1, 1'b0, 5'd3, '1, '1, 1'b1);
        step();
        total++; if (cfg_gnt !== 1'b0 || rf_WriteEnable !== 1'b0) begin bad++; $display("FAIL rst_wr got=%0b%0b want=00", cfg_gnt, rf_WriteEnable); end
        total++; if (rf_WriteData !== '0 || rf_WriteBE !== '0 || rf_WriteAddr !== '0) begin bad++; $display("FAIL rst_wr_bus got=%h/%h/%0d want=0", rf_WriteData, rf_WriteBE, rf_WriteAddr); end
        tick();
        rst = 1'b0;
        idle();
        step();
        total++; if (rf_clear !== 1'b0 || clear_done !== 1'b0 || cfg_gnt !== 1'b0) begin bad++; $display("FAIL rst_release got=%0b%0b%0b want=000", rf_clear, clear_done, cfg_gnt); end
        tick();
    endtask

    task automatic test_write_read();
        logic [AW-1:0] addrs[5];
        logic [DW-1:0] d;
        addrs = '{5'd1, 5'd2, 5'd5, 5'd7, 5'd9};
        for (int i = 0; i < 5; i++) begin
            d = (addrs[i] == 5'd5) ? 32'hAABBCCDD : DW'($urandom);
            drive(1'b1, 1'b0, addrs[i], d, 4'hF, 1'b0);
            step();
            total++; if (cfg_gnt !== 1'b1 || rf_WriteEnable !== 1'b1) begin bad++; $display("FAIL wr_gnt a=%0d got=%0b%0b want=11", addrs[i], cfg_gnt, rf_WriteEnable); end
            total++; if (rf_WriteAddr !== addrs[i] || rf_WriteData !== d || rf_WriteBE !== 4'hF) begin bad++; $display("FAIL wr_bus got=%0d/%h/%h want=%0d/%h/f", rf_WriteAddr, rf_WriteData, rf_WriteBE, addrs[i], d); end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, addrs[i], DW'($urandom), 4'h0, 1'b0);
            step();
            total++; if (cfg_gnt !== 1'b1 || rf_ReadEnable !== 1'b1 || rf_ReadAddr !== addrs[i]) begin bad++; $display("FAIL rd_gnt got=%0b%0b/%0d want=11/%0d", cfg_gnt, rf_ReadEnable, rf_ReadAddr, addrs[i]); end
            total++; if (rf_WriteEnable !== 1'b0) begin bad++; $display("FAIL rd_no_wr got=%0b want=0", rf_WriteEnable); end
            tick();
        end
        idle();
        step();
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 4'hF, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b1 || rf_WriteData !== 32'hDEADBEEF || rf_WriteAddr !== 5'd3) begin bad++; $display("FAIL b2b_wr got=%0b/%h/%0d want=1/deadbeef/3", cfg_gnt, rf_WriteData, rf_WriteAddr); end
        tick();
        drive(1'b1, 1'b1, 5'd7, '0, '0, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b1 || rf_ReadAddr !== 5'd7) begin bad++; $display("FAIL b2b_rd got=%0b/%0d want=1/7", cfg_gnt, rf_ReadAddr); end
        total++; if (cfg_r_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=%0b want=0", cfg_r_valid); end
        tick();
        idle();
        step();
        total++; if (cfg_r_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b want=1", cfg_r_valid); end
        tick();
    endtask

    task automatic test_hazard();
        logic [DW-1:0] rd;
        drive(1'b1, 1'b0, 5'd5, 32'h11223344, 4'h3, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b1 || rf_WriteBE !== 4'h3) begin bad++; $display("FAIL hz_wr got=%0b/%h want=1/3", cfg_gnt, rf_WriteBE); end
        tick();
        drive(1'b1, 1'b1, 5'd5, '0, '0, 1'b0);
        step();
`ifdef HWPE_CTRL_REGFILE_FWD_EN
        total++; if (cfg_gnt !== 1'b1) begin bad++; $display("FAIL hz_fwd_gnt got=%0b want=1", cfg_gnt); end
`else
        total++; if (cfg_gnt !== 1'b0 || rf_ReadEnable !== 1'b0) begin bad++; $display("FAIL hz_bubble got=%0b%0b want=00", cfg_gnt, rf_ReadEnable); end
        tick();
        step();
        total++; if (cfg_gnt !== 1'b1 || rf_ReadAddr !== 5'd5) begin bad++; $display("FAIL hz_after_bubble got=%0b/%0d want=1/5", cfg_gnt, rf_ReadAddr); end
`endif
        tick();
        idle();
        step();
        rd = cfg_r_data;
        total++; if (rd[15:0] !== 16'h3344) begin bad++; $display("FAIL hz_low_half got=%h want=3344", rd[15:0]); end
        total++; if (rd !== 32'hAABB3344) begin bad++; $display("FAIL hz_merge got=%h want=aabb3344", rd); end
        tick();
    endtask

    task automatic test_be_zero();
        int cycles;
        logic got;
        drive(1'b1, 1'b0, 5'd9, 32'h5A5A5A5A, 4'h0, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b1 || rf_WriteEnable !== 1'b1 || rf_WriteBE !== 4'h0) begin bad++; $display("FAIL be0_wr got=%0b%0b/%h want=11/0", cfg_gnt, rf_WriteEnable, rf_WriteBE); end
        tick();
        got = 1'b0;
        cycles = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            drive(1'b1, 1'b1, 5'd9, '0, '0, 1'b0);
            step();
            cycles++;
            if (cfg_gnt === 1'b1) got = 1'b1;
            tick();
        end
        total++; if (!got) begin bad++; $display("FAIL be0_rd_timeout got=no_gnt want=gnt"); end
`ifdef HWPE_CTRL_REGFILE_FWD_EN
        total++; if (cycles !== 1) begin bad++; $display("FAIL be0_rd_cycles got=%0d want=1", cycles); end
`else
        total++; if (cycles !== 2) begin bad++; $display("FAIL be0_rd_cycles got=%0d want=2", cycles); end
`endif
        idle();
        step();
        tick();
    endtask

    task automatic test_clear();
        drive(1'b1, 1'b1, 5'd2, '0, '0, 1'b1);
        step();
        total++; if (cfg_gnt !== 1'b0 || rf_clear !== 1'b0 || rf_ReadEnable !== 1'b0) begin bad++; $display("FAIL clr_c0 got=%0b%0b%0b want=000", cfg_gnt, rf_clear, rf_ReadEnable); end
        tick();
        drive(1'b1, 1'b1, 5'd2, '0, '0, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b0 || rf_clear !== 1'b1 || clear_done !== 1'b0) begin bad++; $display("FAIL clr_c1 got=%0b%0b%0b want=010", cfg_gnt, rf_clear, clear_done); end
        clear_ref();
        tick();
        step();
        total++; if (cfg_gnt !== 1'b0 || rf_clear !== 1'b0 || clear_done !== 1'b1) begin bad++; $display("FAIL clr_c2 got=%0b%0b%0b want=001", cfg_gnt, rf_clear, clear_done); end
        tick();
        step();
        total++; if (cfg_gnt !== 1'b1 || rf_clear !== 1'b0 || clear_done !== 1'b0) begin bad++; $display("FAIL clr_c3 got=%0b%0b%0b want=100", cfg_gnt, rf_clear, clear_done); end
        tick();
        drive(1'b1, 1'b1, 5'd5, '0, '0, 1'b0);
        step();
        tick();
        idle();
        step();
        total++; if (cfg_r_valid !== 1'b1 || cfg_r_data !== '0) begin bad++; $display("FAIL clr_read_zero got=%0b/%h want=1/0", cfg_r_valid, cfg_r_data); end
        tick();
    endtask

    task automatic test_read_then_clear();
        drive(1'b1, 1'b0, 5'd1, 32'h13572468, 4'hF, 1'b0);
        step();
        tick();
        idle();
        step();
        tick();
        drive(1'b1, 1'b1, 5'd1, '0, '0, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b1) begin bad++; $display("FAIL rtc_gnt got=%0b want=1", cfg_gnt); end
        tick();
        drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
        step();
        total++; if (cfg_r_valid !== 1'b1 || cfg_r_data !== 32'h13572468) begin bad++; $display("FAIL rtc_old_data got=%0b/%h want=1/13572468", cfg_r_valid, cfg_r_data); end
        tick();
        idle();
        step();
        total++; if (rf_clear !== 1'b1 || cfg_r_valid !== 1'b0) begin bad++; $display("FAIL rtc_clear got=%0b%0b want=10", rf_clear, cfg_r_valid); end
        clear_ref();
        tick();
        step();
        total++; if (clear_done !== 1'b1) begin bad++; $display("FAIL rtc_done got=%0b want=1", clear_done); end
        tick();
        step();
        total++; if (clear_done !== 1'b0 || rf_clear !== 1'b0) begin bad++; $display("FAIL rtc_no_reclear got=%0b%0b want=00", clear_done, rf_clear); end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        drive(1'b0, 1'b1, '0, '0, '0, 1'b1);
        step();
        tick();
        rst = 1'b1;
        idle();
        step();
        total++; if (rf_clear !== 1'b0 || clear_done !== 1'b0) begin bad++; $display("FAIL rmc_in_rst got=%0b%0b want=00", rf_clear, clear_done); end
        tick();
        rst = 1'b0;
        step();
        total++; if (clear_done !== 1'b0 || rf_clear !== 1'b0 || cfg_gnt !== 1'b0) begin bad++; $display("FAIL rmc_after got=%0b%0b%0b want=000", clear_done, rf_clear, cfg_gnt); end
        total++; if (cfg_r_valid !== 1'b0 || cfg_r_data !== '0 || rf_ReadEnable !== 1'b0 || rf_WriteEnable !== 1'b0) begin bad++; $display("FAIL rmc_outs got=%0b/%h/%0b%0b want=0/0/00", cfg_r_valid, cfg_r_data, rf_ReadEnable, rf_WriteEnable); end
        tick();
        drive(1'b1, 1'b0, 5'd6, 32'h66666666, 4'hF, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b1 || clear_done !== 1'b0) begin bad++; $display("FAIL rmc_first_req got=%0b%0b want=10", cfg_gnt, clear_done); end
        tick();
    endtask

    task automatic test_reset_kills_read();
        drive(1'b1, 1'b0, 5'd4, 32'h44444444, 4'hF, 1'b0);
        step();
        tick();
        drive(1'b1, 1'b1, 5'd2, '0, '0, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b1) begin bad++; $display("FAIL rkr_gnt got=%0b want=1", cfg_gnt); end
        tick();
        rst = 1'b1;
        idle();
        step();
        total++; if (cfg_r_valid !== 1'b0 || cfg_r_data !== '0) begin bad++; $display("FAIL rkr_no_resp got=%0b/%h want=0/0", cfg_r_valid, cfg_r_data); end
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b1, 5'd4, '0, '0, 1'b0);
        step();
        total++; if (cfg_gnt !== 1'b1) begin bad++; $display("FAIL rkr_post_gnt got=%0b want=1", cfg_gnt); end
        tick();
        idle();
        step();
        total++; if (cfg_r_data !== 32'h44444444) begin bad++; $display("FAIL rkr_post_data got=%h want=44444444", cfg_r_data); end
        tick();
        step();
        tick();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        pend_rd = 1'b0;
        rst     = 1'b1;
        idle();
        clear_ref();
        tick();
        tick();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_hazard();
        test_be_zero();
        test_clear();
        test_read_then_clear();
        test_reset_mid_clear();
        test_reset_kills_read();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
